// File: rtl/mcu_seq_pkg.sv
// Shared encodings for the mcu_seq control sequencer: states, opcodes,
// ALU selectors, PSR flag positions, trap causes and decode helpers.
`timescale 1ns/1ps
package mcu_seq_pkg;

    typedef enum logic [2:0] {
        MCU_STATE_RESET   = 3'd0,
        MCU_STATE_FETCH   = 3'd1,
        MCU_STATE_IWAIT   = 3'd2,
        MCU_STATE_DECODE  = 3'd3,
        MCU_STATE_DWAIT   = 3'd4,
        MCU_STATE_EXECUTE = 3'd5,
        MCU_STATE_STALL   = 3'd6,
        MCU_STATE_HALT    = 3'd7
    } mcu_state_e;

    localparam logic [4:0] MCU_ADD    = 5'd0;
    localparam logic [4:0] MCU_ADDC   = 5'd1;
    localparam logic [4:0] MCU_SUB    = 5'd2;
    localparam logic [4:0] MCU_SUBC   = 5'd3;
    localparam logic [4:0] MCU_NAND   = 5'd4;
    localparam logic [4:0] MCU_NOR    = 5'd5;
    localparam logic [4:0] MCU_XOR    = 5'd6;
    localparam logic [4:0] MCU_XNOR   = 5'd7;
    localparam logic [4:0] MCU_ADDI   = 5'd8;
    localparam logic [4:0] MCU_ADDCI  = 5'd9;
    localparam logic [4:0] MCU_SUBI   = 5'd10;
    localparam logic [4:0] MCU_SUBCI  = 5'd11;
    localparam logic [4:0] MCU_NANDI  = 5'd12;
    localparam logic [4:0] MCU_NORI   = 5'd13;
    localparam logic [4:0] MCU_XORI   = 5'd14;
    localparam logic [4:0] MCU_XNORI  = 5'd15;
    localparam logic [4:0] MCU_LOAD   = 5'd16;
    localparam logic [4:0] MCU_LOADI  = 5'd17;
    localparam logic [4:0] MCU_STORE  = 5'd18;
    localparam logic [4:0] MCU_STOREI = 5'd19;
    localparam logic [4:0] MCU_JUMP   = 5'd20;
    localparam logic [4:0] MCU_JZ     = 5'd21;
    localparam logic [4:0] MCU_JC     = 5'd22;
    localparam logic [4:0] MCU_JN     = 5'd23;
    localparam logic [4:0] MCU_HALT   = 5'd24;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_ADDC = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_SUBC = 3'd3;
    localparam logic [2:0] ALU_NAND = 3'd4;
    localparam logic [2:0] ALU_NOR  = 3'd5;
    localparam logic [2:0] ALU_XOR  = 3'd6;
    localparam logic [2:0] ALU_XNOR = 3'd7;

    localparam int APSR_ZERO  = 0;
    localparam int APSR_CARRY = 1;
    localparam int APSR_NEG   = 2;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_IMEM    = 2'd2;
    localparam logic [1:0] TRAP_DMEM    = 2'd3;

    typedef enum logic [2:0] {
        OPC_ALU, OPC_LOAD, OPC_STORE, OPC_JUMP, OPC_JCOND, OPC_HALT, OPC_ILLEGAL
    } op_class_e;

    function automatic op_class_e op_class(input logic [4:0] op);
        case (op)
            MCU_ADD, MCU_ADDC, MCU_SUB, MCU_SUBC, MCU_NAND, MCU_NOR, MCU_XOR, MCU_XNOR,
            MCU_ADDI, MCU_ADDCI, MCU_SUBI, MCU_SUBCI, MCU_NANDI, MCU_NORI, MCU_XORI,
            MCU_XNORI:                      return OPC_ALU;
            MCU_LOAD, MCU_LOADI:            return OPC_LOAD;
            MCU_STORE, MCU_STOREI:          return OPC_STORE;
            MCU_JUMP:                       return OPC_JUMP;
            MCU_JZ, MCU_JC, MCU_JN:         return OPC_JCOND;
            MCU_HALT:                       return OPC_HALT;
            default:                        return OPC_ILLEGAL;
        endcase
    endfunction

    function automatic logic [2:0] alu_sel(input logic [4:0] op);
        case (op)
            MCU_ADD,  MCU_ADDI:  return ALU_ADD;
            MCU_ADDC, MCU_ADDCI: return ALU_ADDC;
            MCU_SUB,  MCU_SUBI:  return ALU_SUB;
            MCU_SUBC, MCU_SUBCI: return ALU_SUBC;
            MCU_NAND, MCU_NANDI: return ALU_NAND;
            MCU_NOR,  MCU_NORI:  return ALU_NOR;
            MCU_XOR,  MCU_XORI:  return ALU_XOR;
            default:             return ALU_XNOR;
        endcase
    endfunction

    function automatic logic jump_taken(input logic [4:0] op, input logic [2:0] psr);
        case (op)
            MCU_JZ:  return psr[APSR_ZERO];
            MCU_JC:  return psr[APSR_CARRY];
            MCU_JN:  return psr[APSR_NEG];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mcu_seq_wait_timer.sv
// Saturating memory wait-state counter; o_expired flags the cycle on which
// one more wait would bring the count up to WAIT_MAX.
`timescale 1ns/1ps
module mcu_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_W'(WAIT_MAX))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count >= CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/mcu_seq.sv
// Multi-cycle control sequencer for the accumulator core: fetch/decode/execute
// with memory wait states, bus timeout, HALT, illegal-opcode trap and stall.
`timescale 1ns/1ps
module mcu_seq
    import mcu_seq_pkg::*;
#(
    parameter int INST_WIDTH  = 5,
    parameter int ALUOP_WIDTH = 3,
    parameter int WAIT_MAX    = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_WIDTH-1:0]  opcode,
    input  logic [2:0]             psr,
    input  logic                   imem_ready,
    input  logic                   dmem_ready,
    input  logic                   stall_req,
    output logic                   imem_update,
    output logic                   dmem_update,
    output logic                   dmem_write,
    output logic                   opcode_update,
    output logic                   psr_update,
    output logic                   res_update,
    output logic [ALUOP_WIDTH-1:0] alu_operation,
    output logic                   pc_count,
    output logic                   pc_load,
    output logic                   halted,
    output logic [1:0]             trap
);
    mcu_state_e r_state;
    logic [1:0] r_trap;
    logic [4:0] w_op;
    op_class_e  w_class;
    logic       w_wait;
    logic       w_ready;
    logic       w_expired;

    assign w_op    = 5'(opcode);
    assign w_class = op_class(w_op);
    assign w_wait  = (r_state == MCU_STATE_IWAIT) || (r_state == MCU_STATE_DWAIT);
    assign w_ready = (r_state == MCU_STATE_IWAIT) ? imem_ready : dmem_ready;

    mcu_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_wait),
        .i_en      (!w_ready),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MCU_STATE_RESET;
            r_trap  <= TRAP_NONE;
        end else begin
            case (r_state)
                MCU_STATE_RESET: r_state <= MCU_STATE_FETCH;
                MCU_STATE_FETCH: r_state <= MCU_STATE_IWAIT;
                MCU_STATE_IWAIT: begin
                    // ready takes priority over a timeout on the same cycle
                    if (imem_ready) begin
                        r_state <= MCU_STATE_DECODE;
                    end else if (w_expired) begin
                        r_state <= MCU_STATE_HALT;
                        r_trap  <= TRAP_IMEM;
                    end
                end
                MCU_STATE_DECODE: begin
                    case (w_class)
                        OPC_LOAD, OPC_STORE: r_state <= MCU_STATE_DWAIT;
                        OPC_HALT:            r_state <= MCU_STATE_HALT;
                        OPC_ILLEGAL: begin
                            r_state <= MCU_STATE_HALT;
                            r_trap  <= TRAP_ILLEGAL;
                        end
                        default:             r_state <= MCU_STATE_EXECUTE;
                    endcase
                end
                MCU_STATE_DWAIT: begin
                    if (dmem_ready) begin
                        r_state <= MCU_STATE_EXECUTE;
                    end else if (w_expired) begin
                        r_state <= MCU_STATE_HALT;
                        r_trap  <= TRAP_DMEM;
                    end
                end
                MCU_STATE_EXECUTE, MCU_STATE_STALL:
                    r_state <= stall_req ? MCU_STATE_STALL : MCU_STATE_FETCH;
                MCU_STATE_HALT:  r_state <= MCU_STATE_HALT;
                default:         r_state <= MCU_STATE_RESET;
            endcase
        end
    end

    always_comb begin
        imem_update   = 1'b0;
        dmem_update   = 1'b0;
        dmem_write    = 1'b0;
        opcode_update = 1'b0;
        psr_update    = 1'b0;
        res_update    = 1'b0;
        alu_operation = '0;
        pc_count      = 1'b0;
        pc_load       = 1'b0;
        halted        = 1'b0;
        case (r_state)
            MCU_STATE_RESET: begin
                opcode_update = 1'b1;
                pc_count      = 1'b1;
            end
            MCU_STATE_FETCH: imem_update = 1'b1;
            MCU_STATE_DECODE: begin
                case (w_class)
                    OPC_ALU: begin
                        alu_operation = ALUOP_WIDTH'(alu_sel(w_op));
                        psr_update    = 1'b1;
                        res_update    = 1'b1;
                    end
                    OPC_LOAD: begin
                        res_update  = 1'b1;
                        dmem_update = 1'b1;
                    end
                    OPC_STORE: begin
                        dmem_write  = 1'b1;
                        dmem_update = 1'b1;
                    end
                    OPC_JUMP:  pc_load = 1'b1;
                    OPC_JCOND: pc_load = jump_taken(w_op, psr);
                    default: ;
                endcase
                pc_count = !pc_load;
            end
            MCU_STATE_DWAIT: begin
                res_update = dmem_ready && (w_class == OPC_LOAD);
                dmem_write = dmem_ready && (w_class == OPC_STORE);
            end
            MCU_STATE_EXECUTE, MCU_STATE_STALL: begin
                opcode_update = !stall_req;
                pc_count      = !stall_req;
            end
            MCU_STATE_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign trap = r_trap;

endmodule

// File: tb/tb_mcu_seq.sv
// Cycle-by-cycle directed bench for mcu_seq: the driver queues the expected
// output vector for each cycle, a monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_mcu_seq;
    localparam logic [4:0] OP_ADD = 5'd0,  OP_XNOR = 5'd7,  OP_SUBCI = 5'd11;
    localparam logic [4:0] OP_LOAD = 5'd16, OP_STORE = 5'd18, OP_JUMP = 5'd20;
    localparam logic [4:0] OP_JZ = 5'd21, OP_JC = 5'd22, OP_JN = 5'd23;
    localparam logic [4:0] OP_HALT = 5'd24, OP_BAD = 5'd25;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] psr;
    logic       imem_ready, dmem_ready, stall_req;
    logic       imem_update, dmem_update, dmem_write, opcode_update;
    logic       psr_update, res_update, pc_count, pc_load, halted;
    logic [2:0] alu_operation;
    logic [1:0] trap;

    mcu_seq #(.INST_WIDTH(5), .ALUOP_WIDTH(3), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .psr(psr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stall_req(stall_req),
        .imem_update(imem_update), .dmem_update(dmem_update), .dmem_write(dmem_write),
        .opcode_update(opcode_update), .psr_update(psr_update), .res_update(res_update),
        .alu_operation(alu_operation), .pc_count(pc_count), .pc_load(pc_load),
        .halted(halted), .trap(trap)
    );

    always #5 clk = ~clk;

    logic [13:0] w_out;
    assign w_out = {imem_update, dmem_update, dmem_write, opcode_update, psr_update,
                    res_update, alu_operation, pc_count, pc_load, halted, trap};

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_err = 0;
    logic [4:0]  cur_op;
    logic [2:0]  cur_psr;
    logic [13:0] O_ZERO, O_FETCH, O_EXEC;

    // fields: imem_upd dmem_upd dmem_wr op_upd psr_upd res_upd alu pc_count pc_load halted trap
    function automatic logic [13:0] mk(input bit iu, input bit du, input bit dw, input bit ou,
                                       input bit pu, input bit ru, input logic [2:0] alu,
                                       input bit pcc, input bit pcl, input bit hlt,
                                       input logic [1:0] tr);
        return {iu, du, dw, ou, pu, ru, alu, pcc, pcl, hlt, tr};
    endfunction

    task automatic cyc(input string nm, input logic [13:0] e, input bit ir = 1'b1,
                       input bit dr = 1'b1, input bit st = 1'b0, input bit rs = 1'b0,
                       input bit chk = 1'b1);
        @(posedge clk);
        #1;
        opcode     = cur_op;
        psr        = cur_psr;
        imem_ready = ir;
        dmem_ready = dr;
        stall_req  = st;
        rst        = rs;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    task automatic fetch2(input string nm);
        cyc({nm, "_fetch"}, O_FETCH);
        cyc({nm, "_iwait"}, O_ZERO);
    endtask

    task automatic simple(input string nm, input logic [4:0] op, input logic [2:0] ps,
                          input logic [13:0] dec);
        cur_op  = op;
        cur_psr = ps;
        fetch2(nm);
        cyc({nm, "_decode"}, dec);
        cyc({nm, "_exec"}, O_EXEC);
    endtask

    initial begin : monitor
        logic [13:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                n_chk++;
                if (w_out === e) n_pass++;
                else $display("FAIL %s: outputs %b, expected %b", n, w_out, e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin : driver
        O_ZERO  = '0;
        O_FETCH = mk(1,0,0,0,0,0,3'd0,0,0,0,2'd0);
        O_EXEC  = mk(0,0,0,1,0,0,3'd0,1,0,0,2'd0);
        cur_op = OP_ADD; cur_psr = 3'b000;
        rst = 1'b1; opcode = OP_ADD; psr = 3'b000;
        imem_ready = 1'b0; dmem_ready = 1'b0; stall_req = 1'b0;

        cyc("pre", O_ZERO, 0, 0, 0, 1, 0);
        cyc("pre", O_ZERO, 0, 0, 0, 1, 0);
        cyc("reset_state", O_EXEC, 0, 0, 0, 0);

        // ALU ops, four cycles each with immediate IMEM ready
        simple("add",   OP_ADD,   3'b000, mk(0,0,0,0,1,1,3'd0,1,0,0,2'd0));
        simple("subci", OP_SUBCI, 3'b000, mk(0,0,0,0,1,1,3'd3,1,0,0,2'd0));
        simple("xnor",  OP_XNOR,  3'b000, mk(0,0,0,0,1,1,3'd7,1,0,0,2'd0));

        // jumps: taken forces pc_count low
        simple("jz_taken", OP_JZ,   3'b001, mk(0,0,0,0,0,0,3'd0,0,1,0,2'd0));
        simple("jz_not",   OP_JZ,   3'b000, mk(0,0,0,0,0,0,3'd0,1,0,0,2'd0));
        simple("jc_taken", OP_JC,   3'b010, mk(0,0,0,0,0,0,3'd0,0,1,0,2'd0));
        simple("jn_not",   OP_JN,   3'b011, mk(0,0,0,0,0,0,3'd0,1,0,0,2'd0));
        simple("jn_taken", OP_JN,   3'b100, mk(0,0,0,0,0,0,3'd0,0,1,0,2'd0));
        simple("jump",     OP_JUMP, 3'b000, mk(0,0,0,0,0,0,3'd0,0,1,0,2'd0));

        // stall_req ignored before EXECUTE, then held for 5 cycles
        cur_op = OP_ADD; cur_psr = 3'b000;
        cyc("stl_fetch", O_FETCH, 1, 1, 1);
        cyc("stl_iwait", O_ZERO, 1, 1, 1);
        cyc("stl_decode", mk(0,0,0,0,1,1,3'd0,1,0,0,2'd0), 1, 1, 1);
        for (int i = 0; i < 5; i++) cyc("stl_hold", O_ZERO, 1, 1, 1);
        cyc("stl_resume", O_EXEC, 1, 1, 0);

        // LOAD with three DMEM wait cycles: 8 cycles total
        cur_op = OP_LOAD;
        fetch2("load");
        cyc("load_decode", mk(0,1,0,0,0,1,3'd0,1,0,0,2'd0));
        for (int i = 0; i < 3; i++) cyc("load_dwait", O_ZERO, 1, 0);
        cyc("load_ready", mk(0,0,0,0,0,1,3'd0,0,0,0,2'd0), 1, 1);
        cyc("load_exec", O_EXEC);

        // STORE, DMEM ready on first DWAIT cycle
        cur_op = OP_STORE;
        fetch2("store");
        cyc("store_decode", mk(0,1,1,0,0,0,3'd0,1,0,0,2'd0));
        cyc("store_ready", mk(0,0,1,0,0,0,3'd0,0,0,0,2'd0));
        cyc("store_exec", O_EXEC);

        // reset asserted mid-DWAIT with dmem_ready low
        cur_op = OP_LOAD;
        fetch2("rstdw");
        cyc("rstdw_decode", mk(0,1,0,0,0,1,3'd0,1,0,0,2'd0), 1, 0);
        cyc("rstdw_dwait", O_ZERO, 1, 0);
        cyc("rstdw_dwait_rst", O_ZERO, 1, 0, 0, 1);
        cyc("rstdw_reset", O_EXEC, 1, 0);

        // IMEM never ready: 15 IWAIT cycles then HALT with trap 2
        cur_op = OP_ADD;
        cyc("itmo_fetch", O_FETCH, 0);
        for (int i = 0; i < 15; i++) cyc("itmo_iwait", O_ZERO, 0);
        cyc("itmo_halt", mk(0,0,0,0,0,0,3'd0,0,0,1,2'd2), 1, 1, 1);
        cyc("itmo_halt_hold", mk(0,0,0,0,0,0,3'd0,0,0,1,2'd2), 1, 1, 0);
        cyc("itmo_halt_rst", mk(0,0,0,0,0,0,3'd0,0,0,1,2'd2), 1, 1, 0, 1);
        cyc("itmo_reset", O_EXEC);

        // IMEM ready on the 15th IWAIT cycle: no trap
        cyc("ilate_fetch", O_FETCH, 0);
        for (int i = 0; i < 14; i++) cyc("ilate_iwait", O_ZERO, 0);
        cyc("ilate_ready", O_ZERO, 1);
        cyc("ilate_decode", mk(0,0,0,0,1,1,3'd0,1,0,0,2'd0));
        cyc("ilate_exec", O_EXEC);

        // DMEM never ready: trap 3
        cur_op = OP_LOAD;
        fetch2("dtmo");
        cyc("dtmo_decode", mk(0,1,0,0,0,1,3'd0,1,0,0,2'd0), 1, 0);
        for (int i = 0; i < 15; i++) cyc("dtmo_dwait", O_ZERO, 1, 0);
        cyc("dtmo_halt", mk(0,0,0,0,0,0,3'd0,0,0,1,2'd3), 1, 0, 0, 1);
        cyc("dtmo_reset", O_EXEC);

        // illegal opcode: only pc_count in decode, then trap 1
        cur_op = OP_BAD;
        fetch2("ill");
        cyc("ill_decode", mk(0,0,0,0,0,0,3'd0,1,0,0,2'd0));
        cyc("ill_halt", mk(0,0,0,0,0,0,3'd0,0,0,1,2'd1), 1, 1, 1);
        cyc("ill_halt_rst", mk(0,0,0,0,0,0,3'd0,0,0,1,2'd1), 1, 1, 0, 1);
        cyc("ill_reset", O_EXEC);

        // HALT opcode: halted with no trap cause
        cur_op = OP_HALT;
        fetch2("hlt");
        cyc("hlt_decode", mk(0,0,0,0,0,0,3'd0,1,0,0,2'd0));
        cyc("hlt_halt", mk(0,0,0,0,0,0,3'd0,0,0,1,2'd0));
        cyc("hlt_halt_rst", mk(0,0,0,0,0,0,3'd0,0,0,1,2'd0), 1, 1, 0, 1);
        cyc("hlt_reset", O_EXEC);

        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations never compared", exp_q.size());
            n_err++;
        end
        if (n_chk == 0) begin
            $display("FAIL count: no checks were performed");
            n_err++;
        end
        if (n_pass != n_chk) begin
            $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
            n_err++;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        if (n_err != 0) $fatal(1);
        $finish;
    end

endmodule
